// File: rtl/check_prime_pkg.sv
// check_prime_pkg: shared FSM state type, latency width and sizing helpers
// for the sequential trial-division prime checker.
package check_prime_pkg;

    localparam int LAT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DIV,
        ST_NEXT,
        ST_DONE
    } state_t;

    // Width of the divisor register: enough for the largest odd divisor plus 2.
    function automatic int half_w(input int w);
        return (w + 1) / 2 + 1;
    endfunction

    // Largest odd d with d*d <= 2^w - 1 (integer square root, rounded down to odd).
    function automatic int dmax(input int w);
        longint unsigned maxv;
        longint unsigned root;
        longint unsigned trial;
        maxv = (64'd1 << w) - 64'd1;
        root = 64'd0;
        for (int b = 16; b >= 0; b--) begin
            trial = root | (64'd1 << b);
            if (trial * trial <= maxv) begin
                root = trial;
            end
        end
        if (root[0] == 1'b0) begin
            root = root - 64'd1;
        end
        return int'(root);
    endfunction

    // Number of odd divisors 3..dmax tested by a constant-time check.
    function automatic int nct(input int w);
        return (dmax(w) - 1) / 2;
    endfunction

endpackage

// File: rtl/check_prime_seq_if.sv
// check_prime_seq_if: start/done handshake, candidate and result bundle
// between a requester (master) and the prime checker (slave).
interface check_prime_seq_if #(
    parameter int WIDTH = 8
);
    logic                              start;
    logic [WIDTH-1:0]                  num;
    logic                              busy;
    logic                              done;
    logic                              is_prime;
    logic [check_prime_pkg::LAT_W-1:0] lat_cycles;

    modport master (
        output start,
        output num,
        input  busy,
        input  done,
        input  is_prime,
        input  lat_cycles
    );

    modport slave (
        input  start,
        input  num,
        output busy,
        output done,
        output is_prime,
        output lat_cycles
    );
endinterface

// File: rtl/mod_serial.sv
// mod_serial: restoring shift-subtract remainder unit. A load performs the
// first bit step from the num/d inputs directly, the remaining WIDTH-1 steps
// follow on the captured operands, so valid rises after exactly WIDTH cycles.
module mod_serial
    import check_prime_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int HW    = half_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] num,
    input  logic [HW-1:0]    d,
    output logic [WIDTH-1:0] rem,
    output logic             valid
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [HW-1:0]    r_dv;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;

    logic [WIDTH-1:0] w_src_rem;
    logic             w_src_bit;
    logic [HW-1:0]    w_src_d;
    logic [WIDTH:0]   w_part;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_step;

    // One restoring step: shift in the next dividend bit, subtract d if it fits.
    always_comb begin
        w_src_rem = load ? '0 : r_rem;
        w_src_bit = load ? num[WIDTH-1] : r_q[WIDTH-1];
        w_src_d   = load ? d : r_dv;
        w_part    = {w_src_rem, w_src_bit};
        w_diff    = w_part[WIDTH-1:0] - WIDTH'(w_src_d);
        w_step    = (w_part >= (WIDTH+1)'(w_src_d)) ? w_diff : w_part[WIDTH-1:0];
    end

    // Operand capture on load, then one quotient bit per cycle until the count empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_rem   <= '0;
            r_dv    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_q     <= {num[WIDTH-2:0], 1'b0};
            r_dv    <= d;
            r_rem   <= w_step;
            r_cnt   <= CW'(WIDTH - 1);
            r_valid <= 1'b0;
        end else if (r_cnt != '0) begin
            r_q     <= {r_q[WIDTH-2:0], 1'b0};
            r_rem   <= w_step;
            r_cnt   <= r_cnt - CW'(1);
            r_valid <= (r_cnt == CW'(1));
        end
    end

    assign rem   = r_rem;
    assign valid = r_valid;

endmodule

// File: rtl/check_prime_seq.sv
// check_prime_seq: sequential primality checker using trial division by odd
// divisors through mod_serial, with a start/done handshake and per-check
// latency reporting. Defining CHECK_PRIME_CONST_TIME_EN makes every check run
// all odd divisors up to dmax(WIDTH) so latency is independent of the input.
module check_prime_seq
    import check_prime_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    check_prime_seq_if.slave bus
);
    localparam int HW  = half_w(WIDTH);
    localparam int SQW = 2 * HW;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_num;
    logic [HW-1:0]    r_d;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] r_lat;
    logic             r_is_prime;

    logic [HW-1:0]    w_d_load;
    logic [SQW-1:0]   w_num_ext;
    logic [SQW-1:0]   w_dsq_cur;
    logic [WIDTH-1:0] w_rem;
    logic             w_rem_valid;
    logic             w_divides;
    logic             w_trivial;
    logic             w_trivial_prime;
    logic             w_accept;
    logic             w_busy;
    logic             w_load;
    logic             w_enter_done;
    logic             w_result;

`ifdef CHECK_PRIME_CONST_TIME_EN
    localparam logic [HW-1:0] DMAX_D = HW'(dmax(WIDTH));
    logic             r_composite;
`else
    logic [SQW-1:0]   w_dsq_load;
    assign w_dsq_load = SQW'(w_d_load) * SQW'(w_d_load);
`endif

    assign w_num_ext       = SQW'(r_num);
    assign w_dsq_cur       = SQW'(r_d) * SQW'(r_d);
    assign w_d_load        = (r_state == ST_CHECK) ? HW'(3) : (r_d + HW'(2));
    assign w_divides       = (w_rem == '0) && (w_dsq_cur <= w_num_ext);
    assign w_trivial       = (r_num < WIDTH'(4)) || !r_num[0];
    assign w_trivial_prime = (r_num == WIDTH'(2)) || (r_num == WIDTH'(3));
    assign w_accept        = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    mod_serial #(
        .WIDTH(WIDTH)
    ) u_mod_serial (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .num   (r_num),
        .d     (w_d_load),
        .rem   (w_rem),
        .valid (w_rem_valid)
    );

    // State register; reset drops any check in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: trivial/early exits from CHECK and NEXT, DIV waits on the remainder.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
`ifdef CHECK_PRIME_CONST_TIME_EN
                w_next_state = ST_DIV;
`else
                if (w_trivial || (w_dsq_load > w_num_ext)) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_DIV;
                end
`endif
            end
            ST_DIV: begin
                if (w_rem_valid) begin
                    w_next_state = ST_NEXT;
                end
            end
            ST_NEXT: begin
`ifdef CHECK_PRIME_CONST_TIME_EN
                if (r_d == DMAX_D) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_DIV;
                end
`else
                if (w_divides || (w_dsq_load > w_num_ext)) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_DIV;
                end
`endif
            end
            ST_DONE: begin
                w_next_state = w_accept ? ST_CHECK : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs and control strobes decoded from the current and next state.
    always_comb begin
        w_busy         = (r_state == ST_CHECK) || (r_state == ST_DIV) || (r_state == ST_NEXT);
        w_load         = ((r_state == ST_CHECK) || (r_state == ST_NEXT)) && (w_next_state == ST_DIV);
        w_enter_done   = ((r_state == ST_CHECK) || (r_state == ST_NEXT)) && (w_next_state == ST_DONE);
        bus.busy       = w_busy;
        bus.done       = (r_state == ST_DONE);
        bus.is_prime   = r_is_prime;
        bus.lat_cycles = r_lat;
    end

    // Verdict presented on the edge entering DONE.
    always_comb begin
        w_result = 1'b0;
`ifdef CHECK_PRIME_CONST_TIME_EN
        if (w_trivial) begin
            w_result = w_trivial_prime;
        end else begin
            w_result = !(r_composite || w_divides);
        end
`else
        if (r_state == ST_CHECK) begin
            w_result = w_trivial ? w_trivial_prime : 1'b1;
        end else begin
            w_result = !w_divides;
        end
`endif
    end

    // Operand capture, divisor stepping, cycle counting and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num      <= '0;
            r_d        <= '0;
            r_cnt      <= '0;
            r_lat      <= '0;
            r_is_prime <= 1'b0;
`ifdef CHECK_PRIME_CONST_TIME_EN
            r_composite <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_num      <= bus.num;
                r_cnt      <= LAT_W'(1);
                r_lat      <= '0;
                r_is_prime <= 1'b0;
`ifdef CHECK_PRIME_CONST_TIME_EN
                r_composite <= 1'b0;
`endif
            end else if (w_busy) begin
                r_cnt <= r_cnt + LAT_W'(1);
            end
            if (w_load) begin
                r_d <= w_d_load;
            end
            if (w_enter_done) begin
                r_lat      <= r_cnt + LAT_W'(1);
                r_is_prime <= w_result;
            end
`ifdef CHECK_PRIME_CONST_TIME_EN
            if ((r_state == ST_NEXT) && w_divides) begin
                r_composite <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_check_prime_seq.sv
// tb_check_prime_seq: table vectors, handshake corner sequences, an exhaustive
// sweep and random checks of check_prime_seq against a trial-division model.
module tb_check_prime_seq;

    localparam int WIDTH   = 8;
    localparam int NUM_MAX = (1 << WIDTH) - 1;
    localparam int TIMEOUT = 300;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int num;
        bit prime;
        int lat;
    } vec_t;

    vec_t vecs[$];

    check_prime_seq_if #(.WIDTH(WIDTH)) bus ();

    check_prime_seq #(
        .WIDTH(WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Primality from the definition: no divisor k with 2 <= k <= sqrt(n).
    function automatic bit refIsPrime(input int n);
        if (n < 2) return 1'b0;
        for (int k = 2; k * k <= n; k++) begin
            if (n % k == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Latency: 2 + (divisors tried) * (WIDTH + 1).
    function automatic int refLatency(input int n);
        int cnt;
        cnt = 0;
`ifdef CHECK_PRIME_CONST_TIME_EN
        for (int d = 3; d * d <= NUM_MAX; d += 2) cnt++;
`else
        if (n < 4 || (n % 2) == 0) return 2;
        for (int d = 3; d * d <= n; d += 2) begin
            cnt++;
            if (n % d == 0) break;
        end
`endif
        return 2 + cnt * (WIDTH + 1);
    endfunction

    task automatic addVec(input int n, input bit p, input int l);
        vec_t v;
        v.num   = n;
        v.prime = p;
        v.lat   = l;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Called on a falling edge; holds start for one cycle, then scrambles num.
    task automatic pulseStart(input int n);
        bus.start = 1'b1;
        bus.num   = n[WIDTH-1:0];
        @(negedge clk);
        bus.start = 1'b0;
        bus.num   = WIDTH'($urandom);
    endtask

    // Counts falling edges until done, starting from the given cycle index.
    task automatic waitDone(input string tag, input int startCyc, output int cyc);
        cyc = startCyc;
        while (bus.done !== 1'b1 && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, ".done_seen"}, bus.done, 1);
    endtask

    task automatic applyStimulus(input int n, input bit expPrime, input int expLat, input string tag);
        int cyc;
        pulseStart(n);
        waitDone(tag, 1, cyc);
        checkOutput({tag, ".is_prime"}, bus.is_prime, expPrime);
        checkOutput({tag, ".lat_cycles"}, bus.lat_cycles, expLat);
        checkOutput({tag, ".measured"}, cyc, expLat);
    endtask

    initial begin
        int cyc;
        int n;
        int lat251;

        bus.start = 1'b0;
        bus.num   = '0;
        lat251    = refLatency(251);

        repeat (2) @(negedge clk);
        checkOutput("reset.busy", bus.busy, 0);
        checkOutput("reset.done", bus.done, 0);
        checkOutput("reset.is_prime", bus.is_prime, 0);
        checkOutput("reset.lat_cycles", bus.lat_cycles, 0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef CHECK_PRIME_CONST_TIME_EN
        addVec(2, 1'b1, 65);
        addVec(7, 1'b1, 65);
        addVec(25, 1'b0, 65);
        addVec(97, 1'b1, 65);
        addVec(251, 1'b1, 65);
        addVec(255, 1'b0, 65);
`else
        addVec(7, 1'b1, 2);
        addVec(25, 1'b0, 20);
        addVec(97, 1'b1, 38);
        addVec(251, 1'b1, 65);
        addVec(0, 1'b0, 2);
        addVec(1, 1'b0, 2);
        addVec(2, 1'b1, 2);
        addVec(4, 1'b0, 2);
        addVec(255, 1'b0, 11);
`endif
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].num, vecs[i].prime, vecs[i].lat, $sformatf("vec[%0d]=%0d", i, vecs[i].num));
        end

        // Back-to-back: start issued in the DONE cycle must land in CHECK with cleared results.
        applyStimulus(97, 1'b1, refLatency(97), "b2b.first");
        pulseStart(25);
        checkOutput("b2b.busy", bus.busy, 1);
        checkOutput("b2b.done", bus.done, 0);
        checkOutput("b2b.cleared_prime", bus.is_prime, 0);
        checkOutput("b2b.cleared_lat", bus.lat_cycles, 0);
        waitDone("b2b.second", 1, cyc);
        checkOutput("b2b.is_prime", bus.is_prime, refIsPrime(25));
        checkOutput("b2b.measured", cyc, refLatency(25));

        // Start pulse while busy is ignored and does not queue a second check.
        pulseStart(251);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.num   = WIDTH'(4);
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("busyStart.busy", bus.busy, 1);
        waitDone("busyStart", 5, cyc);
        checkOutput("busyStart.is_prime", bus.is_prime, 1);
        checkOutput("busyStart.lat_cycles", bus.lat_cycles, lat251);
        checkOutput("busyStart.measured", cyc, lat251);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("busyStart.idle%0d.done", k), bus.done, 0);
            checkOutput($sformatf("busyStart.idle%0d.busy", k), bus.busy, 0);
        end

        // Asynchronous reset in the middle of DIV clears everything immediately.
        pulseStart(251);
        repeat (4) @(negedge clk);
        checkOutput("midReset.busy_before", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midReset.busy", bus.busy, 0);
        checkOutput("midReset.done", bus.done, 0);
        checkOutput("midReset.is_prime", bus.is_prime, 0);
        checkOutput("midReset.lat_cycles", bus.lat_cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midReset.idle_busy", bus.busy, 0);
        checkOutput("midReset.idle_done", bus.done, 0);
        applyStimulus(251, 1'b1, lat251, "midReset.rerun");

        // Exhaustive sweep against the model.
        for (int v = 0; v <= NUM_MAX; v++) begin
            applyStimulus(v, refIsPrime(v), refLatency(v), $sformatf("sweep=%0d", v));
        end

        // Random candidates with random idle gaps between requests.
        for (int r = 0; r < 40; r++) begin
            n = int'($urandom_range(0, NUM_MAX));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(n, refIsPrime(n), refLatency(n), $sformatf("rand%0d=%0d", r, n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
